// File: rtl/cnn_stream_io.sv
// cnn_stream_io: pin-side endpoint of the CNN frame protocol.
// Buffers one 75-word input frame (image, two kernel channels, weights, option
// bit) into register files that the compute core reads at random, then sends
// the core's three FP32 results out as three consecutive out_valid cycles.
// Optional build macro: CNN_STREAM_IO_LATCHK_EN (adds a WAIT-state result
// latency watchdog limited to MAX_LAT cycles).
module cnn_stream_io #(
  parameter int DATA_W    = 32,
  parameter int IMG_WORDS = 75,
  parameter int KER_WORDS = 12,
  parameter int WGT_WORDS = 24,
  parameter int MAX_LAT   = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] Img,
  input  logic [DATA_W-1:0] Kernel_ch1,
  input  logic [DATA_W-1:0] Kernel_ch2,
  input  logic [DATA_W-1:0] Weight,
  input  logic              Opt,
  input  logic [6:0]        img_raddr,
  output logic [DATA_W-1:0] img_rdata,
  input  logic [3:0]        ker_raddr,
  output logic [DATA_W-1:0] k1_rdata,
  output logic [DATA_W-1:0] k2_rdata,
  input  logic [4:0]        wgt_raddr,
  output logic [DATA_W-1:0] wgt_rdata,
  output logic              opt_q,
  output logic              load_done,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res0,
  input  logic [DATA_W-1:0] res1,
  input  logic [DATA_W-1:0] res2,
  output logic              proto_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_SEND = 2'd3
  } state_t;

  localparam logic [6:0] LAST_WORD = 7'(IMG_WORDS - 1);

  state_t            state_reg, state_next;
  logic [6:0]        cnt_reg;
  logic [1:0]        idx_reg;
  logic [DATA_W-1:0] res1_reg, res2_reg;
  logic [DATA_W-1:0] out_reg;
  logic              out_valid_reg;
  logic              load_done_reg;
  logic              proto_err_reg;
  logic              opt_reg;

  logic [DATA_W-1:0] img_mem [IMG_WORDS];
  logic [DATA_W-1:0] k1_mem  [KER_WORDS];
  logic [DATA_W-1:0] k2_mem  [KER_WORDS];
  logic [DATA_W-1:0] w_mem   [WGT_WORDS];

  // Control decoded from the FSM each cycle.
  logic       wr_en;
  logic [6:0] wr_addr;
  logic       ld_pulse;
  logic       err_set;
  logic       accept;
  logic       lat_expired;

  logic [IMG_WORDS-1:0] img_we;
  logic [KER_WORDS-1:0] ker_we;
  logic [WGT_WORDS-1:0] wgt_we;

  // Per-word write enables; words beyond a buffer's depth are simply dropped.
  genvar gi;
  generate
    for (gi = 0; gi < IMG_WORDS; gi++) begin : g_img_we
      assign img_we[gi] = wr_en && (wr_addr == 7'(gi));
    end
    for (gi = 0; gi < KER_WORDS; gi++) begin : g_ker_we
      assign ker_we[gi] = wr_en && (wr_addr == 7'(gi));
    end
    for (gi = 0; gi < WGT_WORDS; gi++) begin : g_wgt_we
      assign wgt_we[gi] = wr_en && (wr_addr == 7'(gi));
    end
  endgenerate

`ifdef CNN_STREAM_IO_LATCHK_EN
  localparam logic [8:0] LAT_LAST = 9'(MAX_LAT - 1);
  logic [8:0] lat_cnt_reg;

  // Latency counter: zero in the load_done cycle, counts every WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt_reg <= '0;
    end else if (ld_pulse) begin
      lat_cnt_reg <= '0;
    end else if (state_reg == S_WAIT) begin
      lat_cnt_reg <= lat_cnt_reg + 9'd1;
    end
  end

  assign lat_expired = (lat_cnt_reg == LAT_LAST);
`else
  // Without the watchdog WAIT holds until the core answers.
  assign lat_expired = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    wr_addr    = cnt_reg;
    ld_pulse   = 1'b0;
    err_set    = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        wr_addr = 7'd0;
        if (in_valid) begin
          wr_en      = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (cnt_reg == LAST_WORD) begin
            ld_pulse   = 1'b1;
            state_next = S_WAIT;
          end
        end else begin
          // Frame ended early: flag it and discard the partial frame.
          err_set    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        // Extra words (including the tail of a long frame) are not stored.
        if (in_valid) err_set = 1'b1;
        if (res_valid) begin
          accept     = 1'b1;
          state_next = S_SEND;
        end else if (lat_expired) begin
          err_set    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_SEND: begin
        if (in_valid) err_set = 1'b1;
        if (idx_reg == 2'd3) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Word counter: next word slot while loading, parked at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (wr_en && !ld_pulse) begin
      cnt_reg <= wr_addr + 7'd1;
    end else if (state_next != S_LOAD) begin
      cnt_reg <= '0;
    end
  end

  // Frame buffers and option bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IMG_WORDS; i++) img_mem[i] <= '0;
      for (int i = 0; i < KER_WORDS; i++) begin
        k1_mem[i] <= '0;
        k2_mem[i] <= '0;
      end
      for (int i = 0; i < WGT_WORDS; i++) w_mem[i] <= '0;
      opt_reg <= 1'b0;
    end else begin
      for (int i = 0; i < IMG_WORDS; i++) if (img_we[i]) img_mem[i] <= Img;
      for (int i = 0; i < KER_WORDS; i++) begin
        if (ker_we[i]) begin
          k1_mem[i] <= Kernel_ch1;
          k2_mem[i] <= Kernel_ch2;
        end
      end
      for (int i = 0; i < WGT_WORDS; i++) if (wgt_we[i]) w_mem[i] <= Weight;
      if (wr_en && wr_addr == 7'd0) opt_reg <= Opt;
    end
  end

  // Result serialiser: res0 goes straight to the output register on accept,
  // so only res1/res2 need holding; idx counts the word currently on out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      idx_reg       <= 2'd0;
      res1_reg      <= '0;
      res2_reg      <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_reg       <= res0;
      res1_reg      <= res1;
      res2_reg      <= res2;
      idx_reg       <= 2'd1;
    end else if (state_reg == S_SEND) begin
      case (idx_reg)
        2'd1: begin
          out_reg <= res1_reg;
          idx_reg <= 2'd2;
        end
        2'd2: begin
          out_reg <= res2_reg;
          idx_reg <= 2'd3;
        end
        default: begin
          out_valid_reg <= 1'b0;
          out_reg       <= '0;
          idx_reg       <= 2'd0;
        end
      endcase
    end
  end

  // load_done pulse and sticky protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_done_reg <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      load_done_reg <= ld_pulse;
      if (err_set) proto_err_reg <= 1'b1;
    end
  end

  // Combinational read ports; out-of-range addresses read as zero.
  assign img_rdata = (img_raddr < 7'(IMG_WORDS)) ? img_mem[img_raddr] : '0;
  assign k1_rdata  = (ker_raddr < 4'(KER_WORDS)) ? k1_mem[ker_raddr]  : '0;
  assign k2_rdata  = (ker_raddr < 4'(KER_WORDS)) ? k2_mem[ker_raddr]  : '0;
  assign wgt_rdata = (wgt_raddr < 5'(WGT_WORDS)) ? w_mem[wgt_raddr]   : '0;

  assign opt_q     = opt_reg;
  assign load_done = load_done_reg;
  assign proto_err = proto_err_reg;
  assign out_valid = out_valid_reg;
  assign out       = out_reg;

endmodule

// File: tb/tb_cnn_stream_io.sv
// tb_cnn_stream_io: directed bench for cnn_stream_io. Result words are pushed
// to a scoreboard queue when res_valid is driven and popped by an output
// monitor whenever out_valid is seen.
module tb_cnn_stream_io;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] Img, Kernel_ch1, Kernel_ch2, Weight;
  logic        Opt;
  logic [6:0]  img_raddr;
  logic [31:0] img_rdata;
  logic [3:0]  ker_raddr;
  logic [31:0] k1_rdata, k2_rdata;
  logic [4:0]  wgt_raddr;
  logic [31:0] wgt_rdata;
  logic        opt_q, load_done;
  logic        res_valid;
  logic [31:0] res0, res1, res2;
  logic        proto_err, out_valid;
  logic [31:0] out;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb[$];

  cnn_stream_io dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .Img(Img),
    .Kernel_ch1(Kernel_ch1), .Kernel_ch2(Kernel_ch2), .Weight(Weight), .Opt(Opt),
    .img_raddr(img_raddr), .img_rdata(img_rdata), .ker_raddr(ker_raddr),
    .k1_rdata(k1_rdata), .k2_rdata(k2_rdata), .wgt_raddr(wgt_raddr),
    .wgt_rdata(wgt_rdata), .opt_q(opt_q), .load_done(load_done),
    .res_valid(res_valid), .res0(res0), .res1(res1), .res2(res2),
    .proto_err(proto_err), .out_valid(out_valid), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Output monitor: every out_valid word must match the scoreboard head,
  // and out must read 0 whenever out_valid is low.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) chk("out_unexpected", {31'b0, out_valid}, 32'd0);
        else                chk("out_word", out, sb.pop_front());
      end else begin
        chk("out_idle_zero", out, 32'd0);
      end
    end
  end

  // Drive frame words first..first+n-1 one per cycle; returns at the negedge
  // following the last word with in_valid still high.
  task automatic drive_words(input int first, input int n, input logic [31:0] base, input logic opt);
    for (int i = first; i < first + n; i++) begin
      in_valid   = 1'b1;
      Img        = base + 32'(i);
      Kernel_ch1 = base + 32'h100 + 32'(i);
      Kernel_ch2 = base + 32'h200 + 32'(i);
      Weight     = base + 32'h300 + 32'(i);
      Opt        = (i == 0) ? opt : 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic chk_reads(input string tag, input logic [31:0] base, input logic opt);
    img_raddr = 7'd74; ker_raddr = 4'd11; wgt_raddr = 5'd23;
    #1;
    chk({tag, "_img74"}, img_rdata, base + 32'd74);
    chk({tag, "_k1_11"}, k1_rdata, base + 32'h10B);
    chk({tag, "_k2_11"}, k2_rdata, base + 32'h20B);
    chk({tag, "_w23"},   wgt_rdata, base + 32'h317);
    chk({tag, "_opt"},   {31'b0, opt_q}, {31'b0, opt});
  endtask

  // Pulse res_valid (caller is at a negedge in WAIT) and check the 3-cycle window.
  task automatic send_results(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
    chk("ov_before", {31'b0, out_valid}, 32'd0);
    res_valid = 1'b1; res0 = r0; res1 = r1; res2 = r2;
    sb.push_back(r0); sb.push_back(r1); sb.push_back(r2);
    @(negedge clk);
    res_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("ov_window", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
    end
    chk("ov_after", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    res_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    in_valid = 1'b0; Img = '0; Kernel_ch1 = '0; Kernel_ch2 = '0; Weight = '0; Opt = 1'b0;
    img_raddr = '0; ker_raddr = '0; wgt_raddr = '0;
    res_valid = 1'b0; res0 = '0; res1 = '0; res2 = '0;

    // Reset state.
    do_reset();
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_proto_err", {31'b0, proto_err}, 32'd0);
    chk("rst_load_done", {31'b0, load_done}, 32'd0);
    chk("rst_opt_q", {31'b0, opt_q}, 32'd0);
    chk("rst_img0", img_rdata, 32'd0);
    @(negedge clk);

    // Nominal frame.
    drive_words(0, 74, 32'h0, 1'b1);
    chk("nom_ld_early", {31'b0, load_done}, 32'd0);
    drive_words(74, 1, 32'h0, 1'b1);
    in_valid = 1'b0;
    chk("nom_load_done", {31'b0, load_done}, 32'd1);
    chk_reads("nom", 32'h0, 1'b1);
    img_raddr = 7'd75; ker_raddr = 4'd12; wgt_raddr = 5'd24;
    #1;
    chk("oor_img", img_rdata, 32'd0);
    chk("oor_ker", k1_rdata, 32'd0);
    chk("oor_wgt", wgt_rdata, 32'd0);
    @(negedge clk);
    chk("nom_ld_once", {31'b0, load_done}, 32'd0);

`ifdef CNN_STREAM_IO_LATCHK_EN
    // Watchdog: load_done was one cycle ago; error appears 200 cycles after it.
    repeat (198) @(negedge clk);
    chk("lat_pre", {31'b0, proto_err}, 32'd0);
    @(negedge clk);
    chk("lat_err", {31'b0, proto_err}, 32'd1);
    // Back in IDLE: a result strobe now is ignored.
    res_valid = 1'b1; res0 = 32'h1; res1 = 32'h2; res2 = 32'h3;
    @(negedge clk);
    res_valid = 1'b0;
    chk("lat_idle_no_out", {31'b0, out_valid}, 32'd0);
    do_reset();
    drive_words(0, 75, 32'h0, 1'b1);
    in_valid = 1'b0;
    chk("lat_reload_ld", {31'b0, load_done}, 32'd1);
    @(negedge clk);
`else
    // Without the watchdog WAIT holds with no error.
    repeat (250) @(negedge clk);
    chk("wait_hold_err", {31'b0, proto_err}, 32'd0);
`endif

    // Result send, then a back-to-back frame starting in the first IDLE cycle.
    send_results(32'h3F800000, 32'h40000000, 32'hBF800000);
    chk("send_proto_err", {31'b0, proto_err}, 32'd0);
    drive_words(0, 10, 32'h1000, 1'b0);
    img_raddr = 7'd50;
    #1;
    chk("b2b_old_word", img_rdata, 32'd50);
    img_raddr = 7'd5;
    #1;
    chk("b2b_new_word", img_rdata, 32'h1005);
    drive_words(10, 65, 32'h1000, 1'b0);
    in_valid = 1'b0;
    chk("b2b_load_done", {31'b0, load_done}, 32'd1);
    chk_reads("b2b", 32'h1000, 1'b0);
    @(negedge clk);
    send_results(32'h11111111, 32'h22222222, 32'h33333333);

    // Short frame: 40 words then drop.
    drive_words(0, 40, 32'h2000, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("short_err", {31'b0, proto_err}, 32'd1);
    chk("short_no_ld", {31'b0, load_done}, 32'd0);
    // res_valid in IDLE is ignored.
    res_valid = 1'b1; res0 = 32'hDEAD; res1 = 32'hBEEF; res2 = 32'hCAFE;
    @(negedge clk);
    res_valid = 1'b0;
    chk("idle_res_ignored", {31'b0, out_valid}, 32'd0);
    drive_words(0, 75, 32'h3000, 1'b1);
    in_valid = 1'b0;
    chk("short_next_ld", {31'b0, load_done}, 32'd1);
    chk_reads("short_next", 32'h3000, 1'b1);
    @(negedge clk);
    send_results(32'h44444444, 32'h55555555, 32'h66666666);

    // Long frame: 76 words.
    do_reset();
    drive_words(0, 75, 32'h4000, 1'b1);
    chk("long_ld", {31'b0, load_done}, 32'd1);
    drive_words(75, 1, 32'h4000, 1'b1);
    in_valid = 1'b0;
    chk("long_ld_once", {31'b0, load_done}, 32'd0);
    chk("long_err", {31'b0, proto_err}, 32'd1);
    chk_reads("long", 32'h4000, 1'b1);
    img_raddr = 7'd0;
    #1;
    chk("long_img0", img_rdata, 32'h4000);
    @(negedge clk);
    send_results(32'h77777777, 32'h88888888, 32'h99999999);

    // Reset during SEND after the first output word.
    do_reset();
    drive_words(0, 75, 32'h5000, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    res_valid = 1'b1; res0 = 32'hAAAA0000; res1 = 32'hBBBB0000; res2 = 32'hCCCC0000;
    sb.push_back(32'hAAAA0000); sb.push_back(32'hBBBB0000); sb.push_back(32'hCCCC0000);
    @(negedge clk);
    res_valid = 1'b0;
    chk("rs_first_ov", {31'b0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rs_async_ov", {31'b0, out_valid}, 32'd0);
    chk("rs_async_out", out, 32'd0);
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rs_no_more_ov", {31'b0, out_valid}, 32'd0);
    drive_words(0, 75, 32'h6000, 1'b1);
    in_valid = 1'b0;
    chk("rs_fresh_ld", {31'b0, load_done}, 32'd1);
    chk_reads("rs_fresh", 32'h6000, 1'b1);
    @(negedge clk);
    send_results(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F);
    chk("rs_err_clear", {31'b0, proto_err}, 32'd0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
